frame_line_scheduler: RTL and testbench
=======================================

Name: frame_line_scheduler

Overview:
- Capture controller for the D5M CCD line path.
- Detects frame and line boundaries from FVAL/LVAL and counts X/Y.
- Sequences pixel writes into an external two-bank (ping-pong) line RAM of COLS pixels per bank.
- Hands completed lines to one downstream consumer through a valid/ack handshake and tracks bank ownership between writer and reader. The pixel RAM itself is external; this block owns all sequencing.

Parameters:
- COLS, 800, pixels stored per line; excess pixels ignored.
- ROWS, 600, lines captured per frame; excess lines ignored.
- AW, 10, write-address width, must satisfy 2^AW >= COLS.
- YW, 10, line-index width, must satisfy 2^YW >= ROWS.

Ports:
- imDRM5_CLOCK  in  1  pixel clock; all logic on rising edge.
- iRST_N  in  1  synchronous, active-low reset.
- iSTART  in  1  one-cycle pulse; arms capture and clears oOVERFLOW.
- iCONTINUOUS  in  1  1 = re-arm automatically after each frame.
- imrCCD_FVAL  in  1  frame valid from sensor.
- imrCCD_LVAL  in  1  line valid from sensor.
- oWR_EN  out  1  write strobe to line RAM.
- oWR_BANK  out  1  bank being written.
- oWR_ADDR  out  AW  pixel column being written.
- oLINE_VALID  out  1  a completed line is available.
- oLINE_BANK  out  1  bank holding the presented line.
- oLINE_Y  out  YW  row index of the presented line.
- iLINE_ACK  in  1  consumer releases the presented line.
- oBUSY  out  1  state is not IDLE.
- oFRAME_DONE  out  1  one-cycle pulse at end of frame.
- oOVERFLOW  out  1  sticky: at least one line was dropped.

Behaviour:
- Reset (iRST_N=0 at an edge): state IDLE; all outputs 0; both banks free; X=Y=0; write bank 0. Applies at any point mid-operation: in-flight line abandoned, queued lines discarded.
- FVAL/LVAL registered once internally; edges detected against that registered copy. All outputs are registered.
- Write latency is exactly 1 cycle: oWR_EN/oWR_ADDR at cycle n+1 describe the pixel sampled at cycle n. The integrator delays imrCCD_DATA by one register to match.
- States and transitions:
  - IDLE: leave on iSTART -> WAIT_FRAME. iSTART is ignored in any other state.
  - WAIT_FRAME: leave on FVAL rising edge -> CAPTURE, with Y=0. If FVAL is already high when armed, that partial frame is skipped.
  - CAPTURE, LVAL rising edge:
    - If write bank is free, or Y>=ROWS applies: start line with X=0.
    - If write bank is still owned by the reader: drop the line, oOVERFLOW<=1, no writes for that line.
  - CAPTURE, LVAL high on an accepted line with X<COLS and Y<ROWS: oWR_EN=1, oWR_ADDR=X, then X++. Pixels at X>=COLS produce no write; X saturates at COLS.
  - CAPTURE, LVAL falling edge:
    - Accepted line with X>0: mark bank full, queue it with its Y, toggle write bank.
    - Always: Y++, saturating at ROWS. Dropped lines also advance Y.
  - CAPTURE, FVAL falling edge -> DONE. An open line is treated as if LVAL fell in the same cycle.
  - DONE: one cycle; oFRAME_DONE=1; then -> WAIT_FRAME if iCONTINUOUS=1, else IDLE.
- Read side, a two-entry in-order queue:
  - oLINE_VALID=1 while the queue is non-empty; oLINE_BANK and oLINE_Y show the oldest entry and hold stable until acked.
  - iLINE_ACK is honoured only while oLINE_VALID=1. That bank is freed at the next edge, and the next entry (if any) is presented at that same edge, so valid stays high.
  - A line posted and an ack landing in the same cycle both take effect; a bank freed this cycle is not writable until the next cycle.
  - Queued lines persist across DONE/IDLE until acked.
- oBUSY=1 in WAIT_FRAME, CAPTURE and DONE.

Optional Feature:
- DROP_COUNT_EN.
- Defined: adds output oDROP_COUNT [15:0], counting dropped lines. Saturates at 16'hFFFF; cleared by reset and by iSTART.
- Undefined: port and counter are absent; oOVERFLOW is the only indication of dropped lines.

Test Plan:
- Bench uses COLS=8, ROWS=4. Reset, iSTART, frame of 4 lines × 8 pixels with LVAL gaps, consumer acks 2 cycles after valid -> 32 writes, addresses 0..7 per line, banks alternate 0,1,0,1. oLINE_Y sequence 0,1,2,3. oFRAME_DONE pulses once, then IDLE. oOVERFLOW=0.
- Line of 12 pixels -> 8 writes (addresses 0..7), line still queued with Y=0.
- Consumer never acks, 3 lines sent -> lines 0 and 1 queued (banks 0, 1), line 2 produces no writes. oOVERFLOW=1. With DROP_COUNT_EN, oDROP_COUNT=1.
- Ack asserted in the same cycle a second line posts -> valid stays high, oLINE_BANK switches to the new bank next cycle, no overflow on the following line.
- iCONTINUOUS=1, iSTART while FVAL is already high -> first partial frame ignored, capture starts at the next FVAL rise, re-arms after oFRAME_DONE.
- iRST_N=0 mid-line (X=5) -> next cycle all outputs 0, IDLE, both banks free; a new iSTART captures normally.

Source files
------------

// File: rtl/frame_line_scheduler.sv
// D5M line-capture sequencer: frame/line detection, ping-pong line RAM write control, line hand-off queue.
// Optional `DROP_COUNT_EN adds oDROP_COUNT, a saturating count of dropped lines.
module frame_line_scheduler #(
    parameter int unsigned COLS = 800,
    parameter int unsigned ROWS = 600,
    parameter int unsigned AW   = 10,
    parameter int unsigned YW   = 10
) (
    input  logic          imDRM5_CLOCK,
    input  logic          iRST_N,
    input  logic          iSTART,
    input  logic          iCONTINUOUS,
    input  logic          imrCCD_FVAL,
    input  logic          imrCCD_LVAL,
    output logic          oWR_EN,
    output logic          oWR_BANK,
    output logic [AW-1:0] oWR_ADDR,
    output logic          oLINE_VALID,
    output logic          oLINE_BANK,
    output logic [YW-1:0] oLINE_Y,
    input  logic          iLINE_ACK,
    output logic          oBUSY,
    output logic          oFRAME_DONE,
    output logic          oOVERFLOW
`ifdef DROP_COUNT_EN
    ,
    output logic [15:0]   oDROP_COUNT
`endif
);

    localparam logic [AW:0] COLS_V = COLS[AW:0];
    localparam logic [YW:0] ROWS_V = ROWS[YW:0];

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;
    state_t state_q;

    logic          fval_q, lval_q, open_q, wbank_q;
    logic [AW:0]   x_q, x_d, x_cur;
    logic [YW:0]   y_q, y_d;
    logic [1:0]    full_q, full_clr, full_set;
    logic [1:0]    qv_q, qbank_q;
    logic [YW-1:0] qy0_q, qy1_q;
    logic          wr_en_q, wr_bank_q, busy_q, done_q, ovf_q;
    logic [AW-1:0] wr_addr_q;

    logic fval_rise, fval_fall, lval_rise, in_cap;
    logic line_close, line_post, line_start, accept, drop, pix_write, ack_take;

    always_comb begin
        fval_rise  = imrCCD_FVAL & ~fval_q;
        fval_fall  = ~imrCCD_FVAL & fval_q;
        lval_rise  = imrCCD_LVAL & ~lval_q;
        in_cap     = (state_q == CAPTURE);
        // A frame end with LVAL still high closes the open line in the same cycle.
        line_close = in_cap & lval_q & (fval_fall | ~imrCCD_LVAL);
        line_post  = line_close & open_q & (x_q != '0);
        line_start = in_cap & ~fval_fall & lval_rise;
        accept     = line_start & (~full_q[wbank_q] | (y_q >= ROWS_V));
        drop       = line_start & ~accept;
        x_cur      = lval_rise ? '0 : x_q;
        pix_write  = in_cap & ~fval_fall & imrCCD_LVAL & (accept | (open_q & ~lval_rise))
                     & (x_cur < COLS_V) & (y_q < ROWS_V);
        ack_take   = qv_q[0] & iLINE_ACK;
        x_d        = pix_write ? x_cur + 1'b1 : x_cur;
        y_d        = (line_close && (y_q < ROWS_V)) ? y_q + 1'b1 : y_q;
        full_clr   = ack_take  ? (2'b01 << qbank_q[0]) : 2'b00;
        full_set   = line_post ? (2'b01 << wbank_q)    : 2'b00;
    end

    always_ff @(posedge imDRM5_CLOCK) begin
        if (!iRST_N) begin
            state_q   <= IDLE;
            fval_q    <= 1'b0;
            lval_q    <= 1'b0;
            open_q    <= 1'b0;
            wbank_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            full_q    <= '0;
            qv_q      <= '0;
            qbank_q   <= '0;
            qy0_q     <= '0;
            qy1_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            fval_q    <= imrCCD_FVAL;
            lval_q    <= imrCCD_LVAL;
            wr_en_q   <= pix_write;
            wr_bank_q <= wbank_q;
            if (pix_write) wr_addr_q <= x_cur[AW-1:0];
            x_q       <= x_d;
            y_q       <= y_d;
            if (line_close) open_q <= 1'b0;
            if (accept)     open_q <= 1'b1;
            if (line_post)  wbank_q <= ~wbank_q;
            if (drop)       ovf_q <= 1'b1;
            full_q    <= (full_q & ~full_clr) | full_set;

            // Two-entry in-order queue; an ack and a post in one cycle both land.
            case ({ack_take, line_post})
                2'b11: begin
                    if (qv_q[1]) begin
                        qbank_q <= {wbank_q, qbank_q[1]};
                        qy0_q   <= qy1_q;
                        qy1_q   <= y_q[YW-1:0];
                    end else begin
                        qbank_q[0] <= wbank_q;
                        qy0_q      <= y_q[YW-1:0];
                    end
                end
                2'b10: begin
                    qv_q       <= {1'b0, qv_q[1]};
                    qbank_q[0] <= qbank_q[1];
                    qy0_q      <= qy1_q;
                end
                2'b01: begin
                    if (qv_q[0]) begin
                        qv_q[1]    <= 1'b1;
                        qbank_q[1] <= wbank_q;
                        qy1_q      <= y_q[YW-1:0];
                    end else begin
                        qv_q[0]    <= 1'b1;
                        qbank_q[0] <= wbank_q;
                        qy0_q      <= y_q[YW-1:0];
                    end
                end
                default: ;
            endcase

            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= iSTART;
                    if (iSTART) begin
                        state_q <= WAIT_FRAME;
                        ovf_q   <= 1'b0;
                    end
                end
                WAIT_FRAME: begin
                    if (fval_rise) begin
                        state_q <= CAPTURE;
                        x_q     <= '0;
                        y_q     <= '0;
                        open_q  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (fval_fall) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= iCONTINUOUS ? WAIT_FRAME : IDLE;
                    busy_q  <= iCONTINUOUS;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DROP_COUNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge imDRM5_CLOCK) begin
        if (!iRST_N) begin
            drop_cnt_q <= '0;
        end else if (iSTART && state_q == IDLE) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign oDROP_COUNT = drop_cnt_q;
`endif

    assign oWR_EN      = wr_en_q;
    assign oWR_BANK    = wr_bank_q;
    assign oWR_ADDR    = wr_addr_q;
    assign oLINE_VALID = qv_q[0];
    assign oLINE_BANK  = qbank_q[0];
    assign oLINE_Y     = qy0_q;
    assign oBUSY       = busy_q;
    assign oFRAME_DONE = done_q;
    assign oOVERFLOW   = ovf_q;

endmodule

// File: tb/tb_frame_line_scheduler.sv
// Bench for frame_line_scheduler with COLS=8, ROWS=4: vector table, directed corner cases, random frames vs a line-level model.
module tb_frame_line_scheduler;
    localparam int unsigned COLS = 8;
    localparam int unsigned ROWS = 4;
    localparam int unsigned AW   = 4;
    localparam int unsigned YW   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          iRST_N = 1'b0, iSTART = 1'b0, iCONTINUOUS = 1'b0;
    logic          fval = 1'b0, lval = 1'b0, iLINE_ACK;
    logic          oWR_EN, oWR_BANK, oLINE_VALID, oLINE_BANK, oBUSY, oFRAME_DONE, oOVERFLOW;
    logic [AW-1:0] oWR_ADDR;
    logic [YW-1:0] oLINE_Y;
`ifdef DROP_COUNT_EN
    logic [15:0]   oDROP_COUNT;
`endif

    frame_line_scheduler #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .YW(YW)) dut (
        .imDRM5_CLOCK(clk), .iRST_N(iRST_N), .iSTART(iSTART), .iCONTINUOUS(iCONTINUOUS),
        .imrCCD_FVAL(fval), .imrCCD_LVAL(lval),
        .oWR_EN(oWR_EN), .oWR_BANK(oWR_BANK), .oWR_ADDR(oWR_ADDR),
        .oLINE_VALID(oLINE_VALID), .oLINE_BANK(oLINE_BANK), .oLINE_Y(oLINE_Y),
        .iLINE_ACK(iLINE_ACK), .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE), .oOVERFLOW(oOVERFLOW)
`ifdef DROP_COUNT_EN
        , .oDROP_COUNT(oDROP_COUNT)
`endif
    );

    int total = 0, bad = 0, done_cnt = 0;
    logic [AW:0] got_wr[$], exp_wr[$];
    logic [YW:0] got_ln[$], exp_ln[$];
    bit   ack_mode = 1'b0, rand_dly = 1'b0;
    logic manual_ack = 1'b0;
    int   ack_dly = 0, wcnt = 0;

    // Monitor plus consumer: logs writes and acked lines, drives iLINE_ACK.
    initial begin
        iLINE_ACK = 1'b0;
        forever begin
            @(negedge clk);
            if (oWR_EN === 1'b1) got_wr.push_back({oWR_BANK, oWR_ADDR});
            if (oFRAME_DONE === 1'b1) done_cnt++;
            if (!ack_mode) begin
                iLINE_ACK = manual_ack;
                wcnt = 0;
            end else if (iLINE_ACK) begin
                iLINE_ACK = 1'b0;
            end else if (oLINE_VALID === 1'b1) begin
                if (wcnt >= ack_dly) begin
                    iLINE_ACK = 1'b1;
                    got_ln.push_back({oLINE_BANK, oLINE_Y});
                    wcnt = 0;
                    if (rand_dly) ack_dly = $urandom_range(0, 2);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_q();
        got_wr.delete(); exp_wr.delete(); got_ln.delete(); exp_ln.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        iRST_N = 1'b0; iSTART = 1'b0; iCONTINUOUS = 1'b0;
        fval = 1'b0; lval = 1'b0; manual_ack = 1'b0;
        tick(); tick();
        iRST_N = 1'b1;
        tick();
        clr_q();
    endtask

    task automatic start_cap();
        iSTART = 1'b1; tick(); iSTART = 1'b0;
    endtask

    task automatic frame_open();
        fval = 1'b1; tick(); tick();
    endtask

    task automatic frame_close();
        fval = 1'b0; tick(); tick(); tick();
    endtask

    task automatic send_line(input int len, input int gap);
        lval = 1'b1;
        repeat (len) tick();
        lval = 1'b0;
        repeat (gap) tick();
    endtask

    // Expected result of an accepted line: up to COLS writes at 0.., then one queued entry.
    task automatic add_line(input logic b, input int y, input int len);
        logic [AW:0] w;
        logic [YW:0] l;
        for (int a = 0; a < len && a < int'(COLS); a++) begin
            w = {b, AW'(a)};
            exp_wr.push_back(w);
        end
        l = {b, YW'(y)};
        exp_ln.push_back(l);
    endtask

    task automatic add_writes_only(input logic b, input int len);
        logic [AW:0] w;
        for (int a = 0; a < len && a < int'(COLS); a++) begin
            w = {b, AW'(a)};
            exp_wr.push_back(w);
        end
    endtask

    task automatic cmp_writes(input string p);
        chk({p, " nwr"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            chk($sformatf("%s wr%0d", p, i), got_wr[i], exp_wr[i]);
    endtask

    task automatic cmp_lines(input string p);
        chk({p, " nln"}, got_ln.size(), exp_ln.size());
        for (int i = 0; i < exp_ln.size() && i < got_ln.size(); i++)
            chk($sformatf("%s ln%0d", p, i), got_ln[i], exp_ln[i]);
    endtask

    task automatic chk_head(input string p, input logic v, input logic b, input int y);
        chk({p, " valid"}, oLINE_VALID, v);
        if (v) begin
            chk({p, " lbank"}, oLINE_BANK, b);
            chk({p, " ly"}, oLINE_Y, y);
        end
    endtask

    typedef struct {
        logic rst, st, fv, lv, ak;
        logic en; logic [AW-1:0] addr; logic wb;
        logic vl; logic lb; logic [YW-1:0] ly;
        logic busy, done;
    } vec_t;
    vec_t tbl[14];

    initial begin
        logic mb;
        int nl, len, gap, y;

        // rst st fv lv ak | en addr wb | vl lb ly | busy done
        tbl[0]  = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0};
        tbl[1]  = '{1,1,0,0,0, 0,0,0, 0,0,0, 1,0};
        tbl[2]  = '{1,0,1,0,0, 0,0,0, 0,0,0, 1,0};
        tbl[3]  = '{1,0,1,1,0, 1,0,0, 0,0,0, 1,0};
        tbl[4]  = '{1,0,1,1,0, 1,1,0, 0,0,0, 1,0};
        tbl[5]  = '{1,0,1,1,0, 1,2,0, 0,0,0, 1,0};
        tbl[6]  = '{1,0,1,0,0, 0,0,0, 1,0,0, 1,0};
        tbl[7]  = '{1,0,1,0,1, 0,0,0, 0,0,0, 1,0};
        tbl[8]  = '{1,0,1,1,0, 1,0,1, 0,0,0, 1,0};
        tbl[9]  = '{1,0,1,0,0, 0,0,0, 1,1,1, 1,0};
        tbl[10] = '{1,0,0,0,0, 0,0,0, 1,1,1, 1,1};
        tbl[11] = '{1,0,0,0,0, 0,0,0, 1,1,1, 0,0};
        tbl[12] = '{1,0,0,0,1, 0,0,0, 0,0,0, 0,0};
        tbl[13] = '{1,0,0,0,0, 0,0,0, 0,0,0, 0,0};

        for (int i = 0; i < 14; i++) begin
            iRST_N = tbl[i].rst; iSTART = tbl[i].st; fval = tbl[i].fv;
            lval = tbl[i].lv; manual_ack = tbl[i].ak;
            tick();
            chk($sformatf("tbl%0d en", i), oWR_EN, tbl[i].en);
            if (tbl[i].en) begin
                chk($sformatf("tbl%0d addr", i), oWR_ADDR, tbl[i].addr);
                chk($sformatf("tbl%0d wbank", i), oWR_BANK, tbl[i].wb);
            end
            chk_head($sformatf("tbl%0d", i), tbl[i].vl, tbl[i].lb, tbl[i].ly);
            chk($sformatf("tbl%0d busy", i), oBUSY, tbl[i].busy);
            chk($sformatf("tbl%0d done", i), oFRAME_DONE, tbl[i].done);
            chk($sformatf("tbl%0d ovf", i), oOVERFLOW, 1'b0);
        end
        manual_ack = 1'b0;

        // Full frame 4x8, consumer acks 2 cycles after valid.
        do_reset();
        ack_mode = 1'b1; rand_dly = 1'b0; ack_dly = 2;
        start_cap();
        frame_open();
        for (int l = 0; l < 4; l++) begin
            send_line(8, 4);
            add_line(l[0], l, 8);
        end
        frame_close();
        cmp_writes("full");
        cmp_lines("full");
        chk("full done_cnt", done_cnt, 1);
        chk("full busy", oBUSY, 1'b0);
        chk("full ovf", oOVERFLOW, 1'b0);

        // Line longer than COLS: writes stop at COLS-1, line stays queued.
        do_reset();
        ack_mode = 1'b0;
        start_cap();
        frame_open();
        send_line(12, 4);
        add_writes_only(1'b0, 12);
        frame_close();
        cmp_writes("long");
        chk_head("long", 1'b1, 1'b0, 0);

        // No acks: third line has no free bank and is dropped.
        do_reset();
        ack_mode = 1'b0;
        start_cap();
        frame_open();
        for (int l = 0; l < 3; l++) send_line(4, 4);
        add_writes_only(1'b0, 4);
        add_writes_only(1'b1, 4);
        frame_close();
        cmp_writes("drop");
        chk("drop ovf", oOVERFLOW, 1'b1);
        chk_head("drop q0", 1'b1, 1'b0, 0);
`ifdef DROP_COUNT_EN
        chk("drop count", oDROP_COUNT, 16'd1);
`endif
        manual_ack = 1'b1; tick(); manual_ack = 1'b0;
        chk_head("drop q1", 1'b1, 1'b1, 1);
        manual_ack = 1'b1; tick(); manual_ack = 1'b0;
        chk_head("drop empty", 1'b0, 1'b0, 0);
        start_cap();
        chk("drop start clears ovf", oOVERFLOW, 1'b0);
        chk("drop start busy", oBUSY, 1'b1);
`ifdef DROP_COUNT_EN
        chk("drop count cleared", oDROP_COUNT, 16'd0);
`endif

        // Ack in the same cycle a second line posts.
        do_reset();
        ack_mode = 1'b0;
        start_cap();
        frame_open();
        send_line(4, 4);
        lval = 1'b1;
        repeat (4) tick();
        lval = 1'b0; manual_ack = 1'b1;
        tick();
        manual_ack = 1'b0;
        chk_head("same", 1'b1, 1'b1, 1);
        repeat (3) tick();
        send_line(4, 4);
        frame_close();
        add_writes_only(1'b0, 4);
        add_writes_only(1'b1, 4);
        add_writes_only(1'b0, 4);
        cmp_writes("same");
        chk("same ovf", oOVERFLOW, 1'b0);
        chk_head("same q0", 1'b1, 1'b1, 1);
        manual_ack = 1'b1; tick(); manual_ack = 1'b0;
        chk_head("same q1", 1'b1, 1'b0, 2);

        // Continuous mode, armed while FVAL already high.
        do_reset();
        ack_mode = 1'b1; ack_dly = 0;
        iCONTINUOUS = 1'b1;
        fval = 1'b1; tick(); tick();
        start_cap();
        send_line(3, 3);
        frame_close();
        frame_open();
        send_line(2, 4);
        send_line(2, 4);
        add_line(1'b0, 0, 2);
        add_line(1'b1, 1, 2);
        fval = 1'b0;
        tick();
        chk("cont done", oFRAME_DONE, 1'b1);
        tick();
        chk("cont rearmed", oBUSY, 1'b1);
        tick();
        frame_open();
        send_line(3, 4);
        add_line(1'b0, 0, 3);
        iCONTINUOUS = 1'b0;
        frame_close();
        cmp_writes("cont");
        cmp_lines("cont");
        chk("cont done_cnt", done_cnt, 2);
        chk("cont idle", oBUSY, 1'b0);

        // Reset mid-line with a line already queued.
        do_reset();
        ack_mode = 1'b0;
        start_cap();
        frame_open();
        send_line(3, 4);
        lval = 1'b1;
        repeat (5) tick();
        iRST_N = 1'b0;
        tick();
        chk("rst wr_en", oWR_EN, 1'b0);
        chk("rst wr_bank", oWR_BANK, 1'b0);
        chk("rst wr_addr", oWR_ADDR, 0);
        chk("rst valid", oLINE_VALID, 1'b0);
        chk("rst lbank", oLINE_BANK, 1'b0);
        chk("rst ly", oLINE_Y, 0);
        chk("rst busy", oBUSY, 1'b0);
        chk("rst done", oFRAME_DONE, 1'b0);
        chk("rst ovf", oOVERFLOW, 1'b0);
        iRST_N = 1'b1; lval = 1'b0; fval = 1'b0;
        tick();
        clr_q();
        ack_mode = 1'b1; ack_dly = 1;
        start_cap();
        frame_open();
        send_line(3, 4);
        send_line(3, 4);
        add_line(1'b0, 0, 3);
        add_line(1'b1, 1, 3);
        frame_close();
        cmp_writes("rst");
        cmp_lines("rst");
        chk("rst ovf after", oOVERFLOW, 1'b0);

        // Random frames against a line-level model; consumer acks within 0..2 cycles.
        do_reset();
        ack_mode = 1'b1; rand_dly = 1'b1; ack_dly = 0;
        mb = 1'b0;
        for (int f = 0; f < 15; f++) begin
            start_cap();
            frame_open();
            nl = $urandom_range(1, 6);
            y = 0;
            for (int l = 0; l < nl; l++) begin
                len = $urandom_range(1, 12);
                gap = $urandom_range(3, 6);
                send_line(len, gap);
                if (y < int'(ROWS)) begin
                    add_line(mb, y, len);
                    mb = ~mb;
                end
                y++;
            end
            frame_close();
        end
        cmp_writes("rnd");
        cmp_lines("rnd");
        chk("rnd done_cnt", done_cnt, 15);
        chk("rnd ovf", oOVERFLOW, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
